// File: rtl/reg_scoreboard_if.sv
// Decode-issue and writeback signals shared by decode and the register scoreboard.
interface reg_scoreboard_if;
    // Handshake: an instruction issues in a cycle where issue_valid and issue_ready are both
    // high; issue_ready is combinational from registered state and may depend on the issue_*
    // fields. The master holds the issue_* fields stable while issue_valid is high and
    // issue_ready is low. Writeback (wb_valid/wb_rd) is a single-cycle notification with no ready.
    logic       issue_valid;
    logic [4:0] issue_rs1;
    logic [4:0] issue_rs2;
    logic       issue_use_rs1;
    logic       issue_use_rs2;
    logic       issue_wreg;
    logic [4:0] issue_rd;
    logic       issue_ready;
    logic       wb_valid;
    logic [4:0] wb_rd;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        output issue_wreg, issue_rd, wb_valid, wb_rd,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        input  issue_wreg, issue_rd, wb_valid, wb_rd,
        output issue_ready
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per architectural register, blocks RAW hazards,
// bounds total outstanding writes and counts stall cycles.
module reg_scoreboard #(
    parameter int CNT_W   = 2,
    parameter int MAX_OUT = 4,
    parameter int STALL_W = 16
) (
    input  logic                         Clock,
    input  logic                         nReset,
    reg_scoreboard_if.slave              bus,
    input  logic                         flush,
    output logic [31:0]                  pending,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic [STALL_W-1:0]           stall_cnt,
    output logic                         err_underflow
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic [31:0]        pending_q, pending_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;

    logic raw1, raw2, full, waw_sat, wr_tracked;
    logic ready, fire, trk_i, trk_w, wb_under;

    // Hazard checks look only at registered state: a writeback releases its register one
    // cycle later, matching the registered register-file read path.
    always_comb begin
        wr_tracked = bus.issue_wreg && (bus.issue_rd != 5'd0);
        raw1       = bus.issue_use_rs1 && (bus.issue_rs1 != 5'd0) && pending_q[bus.issue_rs1];
        raw2       = bus.issue_use_rs2 && (bus.issue_rs2 != 5'd0) && pending_q[bus.issue_rs2];
        full       = wr_tracked && (out_q == OUT_W'(MAX_OUT));
        waw_sat    = wr_tracked && (cnt_q[bus.issue_rd] == CNT_MAX);
        ready      = !flush && !raw1 && !raw2 && !full && !waw_sat;
        fire       = bus.issue_valid && ready;
        trk_i      = fire && wr_tracked;
        trk_w      = bus.wb_valid && (bus.wb_rd != 5'd0) && (cnt_q[bus.wb_rd] != '0) && !flush;
        wb_under   = bus.wb_valid && (bus.wb_rd != 5'd0) && (cnt_q[bus.wb_rd] == '0) && !flush;
    end

    assign bus.issue_ready = ready;

    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (trk_i && (bus.issue_rd == 5'(r))) begin
                cnt_d[r] = cnt_d[r] + CNT_W'(1);
            end
            if (trk_w && (bus.wb_rd == 5'(r))) begin
                cnt_d[r] = cnt_d[r] - CNT_W'(1);
            end
            if (flush) begin
                cnt_d[r] = '0;
            end
            pending_d[r] = (cnt_d[r] != '0);
        end

        // trk_i is already blocked by full, so out_q cannot exceed MAX_OUT here.
        out_d = out_q + OUT_W'(trk_i) - OUT_W'(trk_w);
        if (flush) begin
            out_d = '0;
        end

        stall_d = stall_q;
        if (bus.issue_valid && !ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end

        err_d = err_q | wb_under;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            pending_q <= '0;
            out_q     <= '0;
            stall_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            pending_q <= pending_d;
            out_q     <= out_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
        end
    end

    assign pending       = pending_q;
    assign outstanding   = out_q;
    assign stall_cnt     = stall_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed and randomized checks of reg_scoreboard against a counting reference model.
module tb_reg_scoreboard;
  localparam int CNT_W   = 2;
  localparam int MAX_OUT = 4;
  localparam int STALL_W = 16;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);
  localparam int CNT_LIM = (1 << CNT_W) - 1;

  logic               Clock = 1'b0;
  logic               nReset = 1'b0;
  logic               flush = 1'b0;
  logic [31:0]        pending;
  logic [OUT_W-1:0]   outstanding;
  logic [STALL_W-1:0] stall_cnt;
  logic               err_underflow;

  reg_scoreboard_if bus ();

  reg_scoreboard #(.CNT_W(CNT_W), .MAX_OUT(MAX_OUT), .STALL_W(STALL_W)) dut (
    .Clock(Clock),
    .nReset(nReset),
    .bus(bus),
    .flush(flush),
    .pending(pending),
    .outstanding(outstanding),
    .stall_cnt(stall_cnt),
    .err_underflow(err_underflow)
  );

  always #5 Clock = ~Clock;

  // reference model: in-flight write count per register
  int m_cnt [32];
  int m_out;
  int m_stall;
  bit m_err;
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    bit blocked;
    blocked = flush;
    if (bus.issue_use_rs1 && bus.issue_rs1 != 0 && m_cnt[bus.issue_rs1] > 0) blocked = 1;
    if (bus.issue_use_rs2 && bus.issue_rs2 != 0 && m_cnt[bus.issue_rs2] > 0) blocked = 1;
    if (bus.issue_wreg && bus.issue_rd != 0 &&
        (m_out == MAX_OUT || m_cnt[bus.issue_rd] == CNT_LIM)) blocked = 1;
    return !blocked;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    for (int r = 0; r < 32; r++) p[r] = (m_cnt[r] > 0);
    return p;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_out = 0;
  endtask

  task automatic m_update(input bit rdy);
    bit wb_ok, wb_bad;
    if (bus.issue_valid && !rdy && m_stall < (1 << STALL_W) - 1) m_stall++;
    wb_ok  = bus.wb_valid && bus.wb_rd != 0 && !flush && m_cnt[bus.wb_rd] > 0;
    wb_bad = bus.wb_valid && bus.wb_rd != 0 && !flush && m_cnt[bus.wb_rd] == 0;
    if (wb_bad) m_err = 1;
    if (flush) begin
      m_clear();
    end else begin
      if (wb_ok) begin
        m_cnt[bus.wb_rd]--;
        m_out--;
      end
      if (bus.issue_valid && rdy && bus.issue_wreg && bus.issue_rd != 0) begin
        m_cnt[bus.issue_rd]++;
        m_out++;
      end
    end
  endtask

  task automatic drive_issue(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                             input bit wreg, input int rd);
    bus.issue_valid   = v;
    bus.issue_rs1     = 5'(rs1);
    bus.issue_use_rs1 = u1;
    bus.issue_rs2     = 5'(rs2);
    bus.issue_use_rs2 = u2;
    bus.issue_wreg    = wreg;
    bus.issue_rd      = 5'(rd);
  endtask

  task automatic drive_wb(input bit v, input int rd);
    bus.wb_valid = v;
    bus.wb_rd    = 5'(rd);
  endtask

  task automatic idle();
    drive_issue(0, 0, 0, 0, 0, 0, 0);
    drive_wb(0, 0);
    flush = 1'b0;
  endtask

  // one clock: check combinational ready, advance, check registered outputs
  task automatic step();
    bit exp_rdy;
    #1;
    exp_rdy = m_ready();
    chk("issue_ready", 32'(bus.issue_ready), 32'(exp_rdy));
    @(posedge Clock);
    m_update(exp_rdy);
    @(negedge Clock);
    chk("pending", pending, m_pending());
    chk("outstanding", 32'(outstanding), m_out);
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
  endtask

  task automatic check_reset_values();
    chk("rst_pending", pending, 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_err", 32'(err_underflow), 0);
    chk("rst_ready", 32'(bus.issue_ready), 32'(!flush));
  endtask

  task automatic do_reset();
    @(negedge Clock);
    #2 nReset = 1'b0;
    m_clear();
    m_stall = 0;
    m_err = 0;
    idle();
    #1 check_reset_values();
    @(negedge Clock);
    nReset = 1'b1;
  endtask

  task automatic randomize_inputs();
    drive_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 7));
    drive_wb($urandom_range(0, 1), $urandom_range(0, 7));
    flush = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    idle();
    m_clear();
    m_stall = 0;
    m_err = 0;

    // reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      @(negedge Clock);
      randomize_inputs();
      #1 check_reset_values();
    end
    @(negedge Clock);
    idle();
    nReset = 1'b1;

    // RAW: write rd=5, dependent read stalls until cycle after wb
    drive_issue(1, 0, 0, 0, 0, 1, 5);
    step();
    drive_issue(1, 5, 1, 0, 0, 0, 0);
    step();
    step();
    drive_wb(1, 5);
    #1 chk("raw_wb_cycle_ready", 32'(bus.issue_ready), 0);
    step();
    drive_wb(0, 0);
    chk("raw_stall_cnt", 32'(stall_cnt), 3);
    #1 chk("raw_release_ready", 32'(bus.issue_ready), 1);
    step();
    idle();

    // full: four writes fill the outstanding budget
    for (int r = 1; r <= 4; r++) begin
      drive_issue(1, 0, 0, 0, 0, 1, r);
      step();
    end
    chk("full_outstanding", 32'(outstanding), 4);
    drive_issue(1, 0, 0, 0, 0, 1, 6);
    #1 chk("full_block", 32'(bus.issue_ready), 0);
    step();
    drive_issue(1, 7, 1, 0, 0, 0, 0);
    #1 chk("full_nonwrite_ready", 32'(bus.issue_ready), 1);
    step();
    drive_issue(1, 0, 0, 0, 0, 1, 6);
    drive_wb(1, 1);
    step();
    drive_wb(0, 0);
    #1 chk("full_after_wb_ready", 32'(bus.issue_ready), 1);
    step();
    idle();
    for (int r = 2; r <= 6; r++) begin
      if (r != 5) begin
        drive_wb(1, r);
        step();
      end
    end
    idle();
    chk("full_drained", 32'(outstanding), 0);

    // WAW: saturate rd=9, then same-cycle issue and wb on rd=9
    for (int k = 0; k < 3; k++) begin
      drive_issue(1, 0, 0, 0, 0, 1, 9);
      step();
    end
    #1 chk("waw_sat_block", 32'(bus.issue_ready), 0);
    step();
    idle();
    drive_wb(1, 9);
    step();
    drive_issue(1, 0, 0, 0, 0, 1, 9);
    drive_wb(1, 9);
    step();
    idle();
    chk("waw_pending9", 32'(pending[9]), 1);
    chk("waw_outstanding", 32'(outstanding), 2);
    drive_wb(1, 9);
    step();
    step();
    idle();

    // flush with a concurrent wb
    for (int r = 1; r <= 3; r++) begin
      drive_issue(1, 0, 0, 0, 0, 1, r);
      step();
    end
    drive_issue(1, 0, 0, 0, 0, 1, 4);
    drive_wb(1, 1);
    flush = 1'b1;
    #1 chk("flush_ready", 32'(bus.issue_ready), 0);
    step();
    idle();
    chk("flush_pending", pending, 0);
    chk("flush_outstanding", 32'(outstanding), 0);
    chk("flush_err", 32'(err_underflow), 0);
    drive_wb(1, 3);
    step();
    idle();
    chk("underflow_err", 32'(err_underflow), 1);

    // x0 is never tracked
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive_issue(1, 0, 1, 0, 1, 1, 0);
      drive_wb(k[0], 0);
      step();
    end
    idle();
    chk("x0_pending", pending, 0);
    chk("x0_stall", 32'(stall_cnt), 0);
    chk("x0_err", 32'(err_underflow), 0);

    // randomized traffic with an asynchronous reset in the middle
    for (int c = 0; c < 600; c++) begin
      randomize_inputs();
      if (c == 300) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    n_mis++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "timeout");
  end
endmodule
